// File: rtl/pdp8_pkg.sv
// Shared PDP-8 serial definitions: receiver states, oversampling constants
// and the baud divider calculation.
package pdp8_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BRK
  } rx_state_t;

  localparam int RX_OVERSAMPLE = 16;
  localparam int RX_HALF_BIT   = RX_OVERSAMPLE / 2;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * RX_OVERSAMPLE) / 2) / (baud * RX_OVERSAMPLE);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running clock divider producing a one-cycle tick every DIV clocks;
// a synchronous clear restarts the period so ticks can be phase-aligned.
module baud_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic nRESET,
  input  logic clr,
  output logic tick
);

  localparam int           W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/kl8_uart_rx.sv
// KL8 console keyboard receiver: 16x oversampled 8N1 deframer feeding the
// keyboard data register and flag. Define KL8_RX_OVERRUN_EN to track overruns.
module kl8_uart_rx
  import pdp8_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       nRESET,
  input  logic       rx,
  input  logic       rd_strobe,
  output logic [7:0] data,
  output logic       flag,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int         DIV       = baud_div(CLK_HZ, BAUD);
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] HALF_LAST = 4'(RX_HALF_BIT - 1);

  logic       rx_p0, rx_p1, rx_p2;
  logic       fall, tick, tick_clr, shift_en, ld;
  rx_state_t  state, state_nxt;
  logic [3:0] tcnt, tcnt_nxt;
  logic [2:0] bcnt, bcnt_nxt;
  logic [7:0] shreg;

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .nRESET (nRESET),
    .clr    (tick_clr),
    .tick   (tick)
  );

  // Stage p0/p1: synchroniser; p2: previous synchronised level for edge detect
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
      rx_p2 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign fall = rx_p2 & ~rx_p1;

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state <= ST_IDLE;
      tcnt  <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_nxt;
      tcnt  <= tcnt_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    bcnt_nxt  = bcnt;
    tick_clr  = 1'b0;
    shift_en  = 1'b0;
    ld        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          tick_clr  = 1'b1;
          tcnt_nxt  = '0;
          bcnt_nxt  = '0;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tcnt == HALF_LAST) begin
            tcnt_nxt  = '0;
            state_nxt = rx_p1 ? ST_IDLE : ST_DATA;
          end else begin
            tcnt_nxt = tcnt + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tcnt == TICK_LAST) begin
            tcnt_nxt = '0;
            shift_en = 1'b1;
            bcnt_nxt = bcnt + 3'd1;
            if (bcnt == 3'd7) state_nxt = ST_STOP;
          end else begin
            tcnt_nxt = tcnt + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tcnt == TICK_LAST) begin
            tcnt_nxt  = '0;
            ld        = 1'b1;
            state_nxt = rx_p1 ? ST_IDLE : ST_BRK;
          end else begin
            tcnt_nxt = tcnt + 4'd1;
          end
        end
      end
      ST_BRK: begin
        if (rx_p1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Partial byte needs no reset: it is only observed through a load.
  always_ff @(posedge clk) begin
    if (shift_en) shreg <= {rx_p1, shreg[7:1]};
  end

  // A load beats a same-cycle read strobe so the new character is never lost.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      data      <= 8'h00;
      flag      <= 1'b0;
      frame_err <= 1'b0;
    end else if (ld) begin
      data      <= shreg;
      flag      <= 1'b1;
      frame_err <= ~rx_p1;
    end else if (rd_strobe) begin
      flag      <= 1'b0;
    end
  end

`ifdef KL8_RX_OVERRUN_EN
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      overrun <= 1'b0;
    end else if (ld) begin
      overrun <= flag & ~rd_strobe;
    end
  end
`else
  assign overrun = 1'b0;
`endif

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_kl8_uart_rx.sv
// Scoreboard bench for kl8_uart_rx at 1.6 MHz / 10 kbaud (160 clocks per bit).
module tb_kl8_uart_rx;

  localparam int BIT_CLKS = 160;
  // 3 clocks of synchroniser/edge detect, then 152 ticks of 10 clocks to mid-stop
  localparam int LOAD_LAT = 3 + 152 * 10;
`ifdef KL8_RX_OVERRUN_EN
  localparam logic OV_EXP = 1'b1;
`else
  localparam logic OV_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nRESET;
  logic       rx;
  logic       rd_strobe;
  logic [7:0] data;
  logic       flag, frame_err, overrun, busy;

  kl8_uart_rx #(
    .CLK_HZ     (1_600_000),
    .BAUD       (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .nRESET    (nRESET),
    .rx        (rx),
    .rd_strobe (rd_strobe),
    .data      (data),
    .flag      (flag),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  d;
    logic        fe;
    logic        ov;
    int unsigned t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // A load shows up as a data change or a rising flag.
  logic [7:0] prev_data = 8'h00;
  logic       prev_flag = 1'b0;
  always @(negedge clk) begin
    if (nRESET === 1'b1 && (data !== prev_data || (flag && !prev_flag))) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_load", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("ld_data", data, mon_e.d);
        check("ld_frame_err", frame_err, mon_e.fe);
        check("ld_overrun", overrun, mon_e.ov);
        check("ld_flag", flag, 1'b1);
        check("ld_latency", cyc - mon_e.t0, LOAD_LAT);
      end
    end
    prev_data <= data;
    prev_flag <= flag;
  end

  task automatic drive_bit(input logic v, input int n);
    rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [7:0] b, input logic fe, input logic ov);
    sb.push_back('{d: b, fe: fe, ov: ov, t0: cyc});
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CLKS);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ov, input int idle);
    send_data(b, 1'b0, ov);
    drive_bit(1'b1, BIT_CLKS + idle);
  endtask

  task automatic pulse_rd();
    rd_strobe = 1'b1;
    @(posedge clk);
    #1;
    rd_strobe = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRESET    = 1'b0;
    rx        = 1'b1;
    rd_strobe = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_data", data, 8'h00);
    check("rst_flag", flag, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    nRESET = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle_busy", busy, 1'b0);

    // False start: 50-clock glitch is high again by the half-bit sample
    drive_bit(1'b0, 50);
    check("fs_busy_rise", busy, 1'b1);
    drive_bit(1'b1, 40);
    check("fs_busy_fall", busy, 1'b0);
    check("fs_flag", flag, 1'b0);
    check("fs_data", data, 8'h00);
    drive_bit(1'b1, 200);

    send_byte(8'hA5, 1'b0, 200);
    wait_drain();
    pulse_rd();
    check("rd_clears_flag", flag, 1'b0);
    check("rd_keeps_data", data, 8'hA5);
    pulse_rd();
    check("rd_idle_flag", flag, 1'b0);
    check("rd_idle_data", data, 8'hA5);

    // Break: stop bit held low for two bit times
    send_data(8'h3C, 1'b1, 1'b0);
    drive_bit(1'b0, 2 * BIT_CLKS);
    check("brk_busy", busy, 1'b1);
    check("brk_frame_err", frame_err, 1'b1);
    drive_bit(1'b1, 20);
    check("brk_exit_busy", busy, 1'b0);
    drive_bit(1'b1, 200);
    wait_drain();
    pulse_rd();
    send_byte(8'h41, 1'b0, 200);
    wait_drain();
    pulse_rd();

    // Back-to-back frames without a read
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, OV_EXP, 200);
    wait_drain();
    check("ov_flag", flag, 1'b1);
    send_byte(8'h33, OV_EXP, 200);
    wait_drain();

    // Read strobe in the same cycle as the load
    fork
      send_byte(8'h7E, 1'b0, 200);
      begin
        repeat (LOAD_LAT - 1) @(posedge clk);
        #1;
        rd_strobe = 1'b1;
        @(posedge clk);
        #1;
        rd_strobe = 1'b0;
      end
    join
    wait_drain();
    check("same_cycle_flag", flag, 1'b1);
    check("same_cycle_overrun", overrun, 1'b0);
    pulse_rd();
    check("post_rd_flag", flag, 1'b0);

    send_byte(8'h99, 1'b0, 200);
    wait_drain();

    // Reset in the middle of data bit 4 of 0xFF
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS / 2);
    check("midframe_busy", busy, 1'b1);
    nRESET = 1'b0;
    #1;
    check("arst_data", data, 8'h00);
    check("arst_flag", flag, 1'b0);
    check("arst_frame_err", frame_err, 1'b0);
    check("arst_overrun", overrun, 1'b0);
    check("arst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    nRESET = 1'b1;
    drive_bit(1'b1, 400);
    check("post_rst_busy", busy, 1'b0);
    send_byte(8'h55, 1'b0, 200);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
